// File: rtl/sched_pkg.sv
// Shared definitions for round-robin schedulers in the child hierarchy.
package sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } sched_state_e;

  localparam int DEF_N_REQ    = 5;
  localparam int DEF_MAX_HOLD = 16;

  // Reference round-robin pick for up to 16 requesters: returns {found, idx}.
  // Scans ptr, ptr+1, ... wrapping at n; the first set request wins.
  function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [4:0] res;
    int         j;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if ((k < n) && req[j]) begin
        res = {1'b1, 4'(j)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Rotate-priority encoder: rotate req by ptr, find first set, un-rotate.
module rr_pick_comb #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot_s;
  logic [W-1:0] off_s;
  logic [W:0]   sum_s;

  // Rotate so that bit 0 of rot_s is the requester at ptr_i.
  always_comb begin
    int src;
    rot_s = '0;
    for (int i = 0; i < N; i++) begin
      src = i + int'(ptr_i);
      if (src >= N) begin
        src = src - N;
      end else begin
        src = src;
      end
      rot_s[i] = req_i[src];
    end
  end

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    found_o = 1'b0;
    off_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found_o = 1'b1;
        off_s   = W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Un-rotate: winner index is (ptr + offset) mod N.
  always_comb begin
    sum_s = {1'b0, ptr_i} + {1'b0, off_s};
    if (sum_s >= (W+1)'(N)) begin
      idx_o = W'(sum_s - (W+1)'(N));
    end else begin
      idx_o = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/child_rr_scheduler.sv
// Round-robin scheduler sharing one resource among N_REQ child instances,
// with grant locking, bounded hold time and a one-cycle turnaround gap.
module child_rr_scheduler
  import sched_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic             preempt
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  sched_state_e     state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [CW-1:0]    hold_cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             busy_q;
  logic             preempt_q;

  logic             pick_found_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [N_REQ-1:0] pick_onehot_s;
  logic [IDW-1:0]   next_ptr_d;
  logic             owner_req_s;
  logic             others_s;
  logic             preempt_hit_s;

  rr_pick_comb #(.N(N_REQ), .W(IDW)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  assign pick_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
  assign owner_req_s   = req[gnt_id_q];
  assign others_s      = |(req & ~gnt_q);

  // Pointer moves just past the current owner when it gives up the grant.
  always_comb begin
    if (gnt_id_q == IDW'(N_REQ - 1)) begin
      next_ptr_d = '0;
    end else begin
      next_ptr_d = gnt_id_q + IDW'(1);
    end
  end

  // Hold limit only forces a release when someone else is waiting.
  if (MAX_HOLD == 0) begin : g_no_preempt
    assign preempt_hit_s = 1'b0;
  end else begin : g_preempt
    assign preempt_hit_s = (hold_cnt_q >= HOLD_LIM) && others_s;
  end

  // Scheduler FSM with hold counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, TURN: begin
          preempt_q <= 1'b0;
          if (en && pick_found_s) begin
            state_q    <= GRANT;
            gnt_q      <= pick_onehot_s;
            gnt_id_q   <= pick_idx_s;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (!owner_req_s || preempt_hit_s) begin
            // Release wins over the hold limit when both happen together.
            state_q    <= TURN;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= next_ptr_d;
            hold_cnt_q <= '0;
            preempt_q  <= owner_req_s;
          end else begin
            preempt_q <= 1'b0;
            if (hold_cnt_q != HOLD_MAX) begin
              hold_cnt_q <= hold_cnt_q + CW'(1);
            end else begin
              hold_cnt_q <= hold_cnt_q;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          gnt_q      <= '0;
          busy_q     <= 1'b0;
          preempt_q  <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Self-checking bench for child_rr_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_child_rr_scheduler;

  localparam int N  = 5;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         busy;
  logic         preempt;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the resource, how long, and where scanning starts.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_preempt = 1'b0;

  child_rr_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model update on each rising edge from the sampled req/en.
  always @(posedge clk or posedge rst) begin
    logic [N-1:0] others;
    int pick;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_preempt = 1'b0;
    end else begin
      m_preempt = 1'b0;
      if (m_owner >= 0) begin
        m_held++;
        others = req;
        others[m_owner] = 1'b0;
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else if (MH > 0 && m_held >= MH && others != 0) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_preempt = 1'b1;
        end
      end else if (en && (req != 0)) begin
        pick = -1;
        for (int k = N - 1; k >= 0; k--) begin
          if (req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        end
        m_owner = pick;
        m_held = 0;
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    if (!rst) begin
      exp_gnt = (m_owner >= 0) ? (5'd1 << m_owner) : 5'd0;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("preempt", 32'(preempt), 32'(m_preempt));
      if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  initial begin
    logic [N-1:0] lit;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_preempt", 32'(preempt), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    rst = 1'b0;

    // Single requester, then pointer moved past it.
    en = 1'b1; req = 5'b00100;
    tick(); chk("single_gnt", 32'(gnt), 32'h04); chk("single_id", 32'(gnt_id), 32'd2);
    repeat (6) tick();
    req = 5'b00000;
    tick(); chk("single_rel", 32'(gnt), 32'h00);
    tick();
    req = 5'b01001;
    tick(); chk("ptr3_gnt", 32'(gnt), 32'h08); chk("ptr3_id", 32'(gnt_id), 32'd3);
    req = 5'b00000;
    repeat (3) tick();

    // Enable gating.
    en = 1'b0; req = 5'b10000;
    repeat (3) begin tick(); chk("en0_nognt", 32'(gnt), 32'h00); end
    en = 1'b1;
    tick(); chk("en1_gnt", 32'(gnt), 32'h10);
    en = 1'b0;
    repeat (6) begin tick(); chk("en0_hold", 32'(gnt), 32'h10); end
    req = 5'b00000;
    tick(); chk("en0_rel", 32'(gnt), 32'h00);
    en = 1'b1;
    repeat (2) tick();

    // Alone past the hold limit: no preemption.
    req = 5'b00010;
    tick();
    repeat (20) begin
      tick(); chk("alone_gnt", 32'(gnt), 32'h02); chk("alone_pre", 32'(preempt), 32'd0);
    end
    req = 5'b00000;
    repeat (3) tick();

    // Preemption after MH grant cycles with another requester waiting.
    req = 5'b00001;
    tick(); chk("pre_g1", 32'(gnt), 32'h01);
    tick(); chk("pre_g2", 32'(gnt), 32'h01);
    req = 5'b01001;
    tick(); chk("pre_g3", 32'(gnt), 32'h01);
    tick(); chk("pre_g4", 32'(gnt), 32'h01); chk("pre_g4_p", 32'(preempt), 32'd0);
    tick(); chk("pre_pulse", 32'(preempt), 32'd1); chk("pre_turn", 32'(gnt), 32'h00);
    tick(); chk("pre_next", 32'(gnt), 32'h08); chk("pre_clr", 32'(preempt), 32'd0);
    req = 5'b00001;
    tick(); chk("pre_rel3", 32'(gnt), 32'h00);
    tick(); chk("pre_back0", 32'(gnt), 32'h01);
    req = 5'b00000;
    repeat (3) tick();

    // Asynchronous reset in the middle of a grant.
    req = 5'b00100;
    tick(); tick();
    #1 rst = 1'b1;
    #1 chk("arst_gnt", 32'(gnt), 32'h00); chk("arst_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    req = 5'b10001;
    tick(); chk("arst_ptr0", 32'(gnt), 32'h01);
    req = 5'b00000;
    repeat (3) tick();

    // Round-robin rotation with all requesting; owner drops req after 4 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      lit = 5'd1 << (k % N);
      chk("rot_gnt", 32'(gnt), 32'(lit));
      repeat (3) tick();
      req[k % N] = 1'b0;
      tick(); chk("rot_gap", 32'(gnt), 32'h00); chk("rot_nopre", 32'(preempt), 32'd0);
      req = 5'b11111;
    end
    req = 5'b00000;
    repeat (3) tick();

    // Randomized traffic: sticky requests with occasional toggles.
    repeat (3000) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    req = 5'b00000; en = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
